pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
//  Parametrised program-counter generator for the IF stage: produces the fetch address with a valid/ready
//  handshake, redirects on trap or branch, supports halt/resume, and optionally predicts taken branches
//  through a small direct-mapped branch target buffer (BTB). Sits ahead of the instruction fetch unit;
//  redirects arrive from EX (branch) and the trap/CSR logic (trap).
// PARAMETERS
//  ADDR_W      32   fetch address width in bits (>= 8)
//  RESET_PC    0    fetch address after reset (word aligned)
//  BTB_DEPTH   8    BTB entries; power of 2, >= 2; IDX = log2(BTB_DEPTH)
// PORTS
//  clk             in   1       clock, rising edge
//  rst             in   1       asynchronous, active-low reset (asserted at 0)
//  if_ready_i      in   1       IF stage accepts the current pc_o
//  pc_o            out  ADDR_W  fetch address
//  pc_valid_o      out  1       pc_o is a valid fetch request
//  trap_flag_i     in   1       trap redirect request
//  trap_addr_i     in   ADDR_W  trap target
//  branch_flag_i   in   1       branch/jump redirect request (mispredict or taken)
//  branch_addr_i   in   ADDR_W  branch target
//  halt_i          in   1       stop issuing fetches
//  resume_i        in   1       leave HALT
//  misalign_o      out  1       one-cycle pulse: the last redirect target had addr[1:0] != 0
//  pred_taken_o    out  1       current pc_o hit in the BTB; next pc is the predicted target
//  btb_upd_i       in   1       BTB write strobe from EX
//  btb_upd_pc_i    in   ADDR_W  branch instruction address
//  btb_upd_tgt_i   in   ADDR_W  resolved target
//  btb_upd_taken_i in   1       1 = install/refresh entry, 0 = invalidate on tag match
// BEHAVIOUR
//  Reset (rst=0, asynchronous): pc_o=RESET_PC, pc_valid_o=0, misalign_o=0, state=BOOT, all BTB valid bits=0.
//  FSM: BOOT -> RUN after one clock, or on a redirect. RUN -> HALT on halt_i with no redirect.
//       HALT -> RUN on resume_i or on any redirect.
//  pc_valid_o = 1 only in RUN. It is registered from the next state.
//  Accept: accept = pc_valid_o & if_ready_i. Without an accept or a redirect, pc_o holds stable.
//  Next-pc priority per edge:
//   1. trap_flag_i
//   2. branch_flag_i
//   3. accept: predicted target when the BTB hits, else pc_o+4
//   4. hold
//  A redirect applies at the next edge regardless of if_ready_i or state. The un-accepted pc_o is dropped.
//  Redirect target is aligned: pc_o <= {tgt[ADDR_W-1:2],2'b00}.
//  misalign_o=1 for exactly the cycle after a redirect whose tgt[1:0] != 0. Otherwise misalign_o=0.
//  Latency: redirect at edge N -> target on pc_o and pc_valid_o=1 from edge N (visible cycle N+1).
//  Arithmetic: pc_o+4 is modulo 2^ADDR_W, so the wrap from all-ones-minus-3 goes to 0.
//  Halt: if halt_i and accept occur together, pc advances first, then HALT holds the new pc.
//        resume_i returns to RUN with that pc.
//  halt_i is ignored in HALT and BOOT. resume_i is ignored outside HALT.
//  halt_i and resume_i together in HALT: resume wins.
//  Redirect together with halt_i: redirect wins and the state stays or becomes RUN.
//  Reset mid-operation: immediate return to the reset values. Pending redirects and BTB contents are lost.
// CONFIGURATION
//  PC_BTB_EN defined:
//   - BTB entry fields: {valid, tag = pc[ADDR_W-1:IDX+2], target}; index = pc[IDX+1:2].
//   - pred_taken_o is combinational: valid & tag match for the current pc_o, gated by pc_valid_o.
//   - Update at the clock edge on btb_upd_i:
//     - taken=1 writes valid, tag and target.
//     - taken=0 clears valid only if the tag matches.
//   - A same-cycle lookup of an entry being written sees the old contents.
//  PC_BTB_EN undefined:
//   - No BTB storage; btb_upd_* ignored; pred_taken_o tied 0.
//   - Sequential next pc is always pc_o+4.
// TESTING
//  1. Reset release, RESET_PC=0x100, if_ready_i=1
//     -> pc_valid_o=0 for 1 cycle, then pc_o 0x100, 0x104, 0x108.
//  2. if_ready_i=0 for 3 cycles at pc 0x104 -> pc_o stays 0x104, pc_valid_o stays 1; resumes 0x108.
//  3. trap (0x80) and branch (0x200) in the same cycle with if_ready_i=0 -> next pc_o=0x80.
//     Then branch to 0x206 -> pc_o=0x204 and misalign_o pulses for 1 cycle.
//  4. ADDR_W=32, pc 0xFFFFFFFC accepted -> pc_o=0x00000000.
//     halt_i with accept at 0x0 -> pc_valid_o=0, pc_o=0x4.
//     resume_i -> pc_valid_o=1 at 0x4.
//  5. PC_BTB_EN:
//     - update pc=0x10, tgt=0x40, taken=1; fetch reaches 0x10 -> pred_taken_o=1, next pc_o=0x40.
//     - update taken=0 for 0x10 -> next visit goes 0x10 -> 0x14.
//     - aliasing pc 0x30 (BTB_DEPTH=8) with a different tag -> no hit.
//  6. rst asserted mid-stream at pc 0x40 in HALT -> pc_o=RESET_PC, pc_valid_o=0 before the next edge;
//     all BTB entries invalid afterwards.

Source files
------------

// File: rtl/pc_gen.sv
// pc_gen: IF-stage program-counter generator with valid/ready handshake, trap/branch redirect,
// halt/resume and an optional direct-mapped branch target buffer (enabled by defining PC_BTB_EN).
module pc_gen #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int unsigned       BTB_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_ready_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              pc_valid_o,
    input  logic              trap_flag_i,
    input  logic [ADDR_W-1:0] trap_addr_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_addr_i,
    input  logic              halt_i,
    input  logic              resume_i,
    output logic              misalign_o,
    output logic              pred_taken_o,
    input  logic              btb_upd_i,
    input  logic [ADDR_W-1:0] btb_upd_pc_i,
    input  logic [ADDR_W-1:0] btb_upd_tgt_i,
    input  logic              btb_upd_taken_i
);

    typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              valid_q;
    logic              misalign_q;

    logic              accept;
    logic              redirect;
    logic [ADDR_W-1:0] redir_tgt;
    logic [ADDR_W-1:0] pc_plus4;
    logic              hit;
    logic [ADDR_W-1:0] pred_tgt;

    assign accept    = valid_q & if_ready_i;
    assign redirect  = trap_flag_i | branch_flag_i;
    assign redir_tgt = trap_flag_i ? trap_addr_i : branch_addr_i;
    assign pc_plus4  = pc_q + ADDR_W'(4);

`ifdef PC_BTB_EN
    localparam int unsigned IDX   = $clog2(BTB_DEPTH);
    localparam int unsigned TAG_W = ADDR_W - IDX - 2;

    logic [BTB_DEPTH-1:0] btb_valid_q;
    logic [TAG_W-1:0]     btb_tag_q [BTB_DEPTH];
    logic [ADDR_W-3:0]    btb_tgt_q [BTB_DEPTH];

    logic [IDX-1:0]       rd_idx, wr_idx;
    logic [TAG_W-1:0]     rd_tag, wr_tag;
    logic                 unused_btb_bits;

    assign rd_idx = pc_q[IDX+1:2];
    assign rd_tag = pc_q[ADDR_W-1:IDX+2];
    assign wr_idx = btb_upd_pc_i[IDX+1:2];
    assign wr_tag = btb_upd_pc_i[ADDR_W-1:IDX+2];
    assign unused_btb_bits = ^{btb_upd_pc_i[1:0], btb_upd_tgt_i[1:0]};

    // Registered arrays: a lookup in the write cycle still sees the old entry.
    assign hit      = valid_q & btb_valid_q[rd_idx] & (btb_tag_q[rd_idx] == rd_tag);
    assign pred_tgt = {btb_tgt_q[rd_idx], 2'b00};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btb_valid_q <= '0;
        end else if (btb_upd_i) begin
            if (btb_upd_taken_i) begin
                btb_valid_q[wr_idx] <= 1'b1;
            end else if (btb_tag_q[wr_idx] == wr_tag) begin
                btb_valid_q[wr_idx] <= 1'b0;
            end
        end
    end

    // Tag/target payload needs no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (btb_upd_i && btb_upd_taken_i) begin
            btb_tag_q[wr_idx] <= wr_tag;
            btb_tgt_q[wr_idx] <= btb_upd_tgt_i[ADDR_W-1:2];
        end
    end
`else
    logic unused_btb_in;

    assign hit           = 1'b0;
    assign pred_tgt      = '0;
    assign unused_btb_in = ^{btb_upd_i, btb_upd_pc_i, btb_upd_tgt_i, btb_upd_taken_i, BTB_DEPTH};
`endif

    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = {redir_tgt[ADDR_W-1:2], 2'b00};
        end else if (accept) begin
            pc_d = hit ? pred_tgt : pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StBoot;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= redirect & (redir_tgt[1:0] != 2'b00);
            case (state_q)
                StBoot: begin
                    state_q <= StRun;
                    valid_q <= 1'b1;
                end
                StRun: begin
                    if (halt_i && !redirect) begin
                        state_q <= StHalt;
                        valid_q <= 1'b0;
                    end
                end
                StHalt: begin
                    if (resume_i || redirect) begin
                        state_q <= StRun;
                        valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StBoot;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign pc_o         = pc_q;
    assign pc_valid_o   = valid_q;
    assign misalign_o   = misalign_q;
    assign pred_taken_o = hit;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: scoreboard bench for pc_gen; accepted fetches are queued by the stimulus and
// checked by a negedge monitor, with direct checks for stalls, redirects, halt and reset.
module tb_pc_gen;

    localparam int unsigned       ADDR_W    = 32;
    localparam logic [ADDR_W-1:0] RESET_PC  = 32'h100;
    localparam int unsigned       BTB_DEPTH = 8;
`ifdef PC_BTB_EN
    localparam logic BTB_EN = 1'b1;
`else
    localparam logic BTB_EN = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              if_ready_i;
    logic [ADDR_W-1:0] pc_o;
    logic              pc_valid_o;
    logic              trap_flag_i;
    logic [ADDR_W-1:0] trap_addr_i;
    logic              branch_flag_i;
    logic [ADDR_W-1:0] branch_addr_i;
    logic              halt_i;
    logic              resume_i;
    logic              misalign_o;
    logic              pred_taken_o;
    logic              btb_upd_i;
    logic [ADDR_W-1:0] btb_upd_pc_i;
    logic [ADDR_W-1:0] btb_upd_tgt_i;
    logic              btb_upd_taken_i;

    pc_gen #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC),
        .BTB_DEPTH(BTB_DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .if_ready_i     (if_ready_i),
        .pc_o           (pc_o),
        .pc_valid_o     (pc_valid_o),
        .trap_flag_i    (trap_flag_i),
        .trap_addr_i    (trap_addr_i),
        .branch_flag_i  (branch_flag_i),
        .branch_addr_i  (branch_addr_i),
        .halt_i         (halt_i),
        .resume_i       (resume_i),
        .misalign_o     (misalign_o),
        .pred_taken_o   (pred_taken_o),
        .btb_upd_i      (btb_upd_i),
        .btb_upd_pc_i   (btb_upd_pc_i),
        .btb_upd_tgt_i  (btb_upd_tgt_i),
        .btb_upd_taken_i(btb_upd_taken_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [31:0] pc;
        logic        pred;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, want, $time);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic pred);
        exp_t e;
        e.pc   = pc;
        e.pred = pred;
        exp_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every handshake must match the next queued fetch.
    always @(negedge clk) begin
        if (rst && pc_valid_o && if_ready_i) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_fetch: got pc 0x%08h, expected no fetch", pc_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("fetch_pc", pc_o, e.pc);
                check("fetch_pred", {31'b0, pred_taken_o}, {31'b0, e.pred});
            end
        end
    end

    logic [31:0] n1;

    initial begin
        rst = 1'b0;
        if_ready_i = 1'b1;
        trap_flag_i = 1'b0;
        trap_addr_i = '0;
        branch_flag_i = 1'b0;
        branch_addr_i = '0;
        halt_i = 1'b0;
        resume_i = 1'b0;
        btb_upd_i = 1'b0;
        btb_upd_pc_i = '0;
        btb_upd_tgt_i = '0;
        btb_upd_taken_i = 1'b0;

        // Reset values and boot cycle
        cyc(); cyc();
        check("reset_pc", pc_o, 32'h100);
        check("reset_valid", {31'b0, pc_valid_o}, 32'd0);
        check("reset_misalign", {31'b0, misalign_o}, 32'd0);
        check("reset_pred", {31'b0, pred_taken_o}, 32'd0);
        rst = 1'b1;
        push(32'h100, 1'b0);
        push(32'h104, 1'b0);
        cyc();
        check("boot_to_run_valid", {31'b0, pc_valid_o}, 32'd1);
        cyc();
        check("seq_pc", pc_o, 32'h104);

        // Stall: pc holds while if_ready_i is low
        if_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("stall_pc", pc_o, 32'h104);
            check("stall_valid", {31'b0, pc_valid_o}, 32'd1);
        end
        if_ready_i = 1'b1;
        cyc();
        check("resume_seq_pc", pc_o, 32'h108);

        // Trap beats branch, then misaligned branch
        if_ready_i = 1'b0;
        trap_flag_i = 1'b1;
        trap_addr_i = 32'h80;
        branch_flag_i = 1'b1;
        branch_addr_i = 32'h200;
        cyc();
        trap_flag_i = 1'b0;
        branch_addr_i = 32'h206;
        check("trap_priority", pc_o, 32'h80);
        check("trap_misalign", {31'b0, misalign_o}, 32'd0);
        cyc();
        branch_flag_i = 1'b0;
        check("branch_aligned", pc_o, 32'h204);
        check("misalign_pulse", {31'b0, misalign_o}, 32'd1);
        cyc();
        check("misalign_clear", {31'b0, misalign_o}, 32'd0);
        if_ready_i = 1'b1;
        push(32'h204, 1'b0);
        push(32'h208, 1'b0);
        cyc();
        cyc();
        push(32'h20C, 1'b0);
        branch_flag_i = 1'b1;
        branch_addr_i = 32'hFFFF_FFFC;

        // Wrap and halt with accept
        cyc();
        branch_flag_i = 1'b0;
        check("top_pc", pc_o, 32'hFFFF_FFFC);
        push(32'hFFFF_FFFC, 1'b0);
        cyc();
        check("wrap_pc", pc_o, 32'h0);
        halt_i = 1'b1;
        push(32'h0, 1'b0);
        cyc();
        halt_i = 1'b0;
        check("halt_valid", {31'b0, pc_valid_o}, 32'd0);
        check("halt_pc", pc_o, 32'h4);
        cyc();
        check("halt_hold_pc", pc_o, 32'h4);
        halt_i = 1'b1;
        resume_i = 1'b1;
        cyc();
        halt_i = 1'b0;
        resume_i = 1'b0;
        check("resume_valid", {31'b0, pc_valid_o}, 32'd1);
        check("resume_pc", pc_o, 32'h4);
        push(32'h4, 1'b0);
        cyc();

        // BTB install, hit, invalidate, alias
        if_ready_i = 1'b0;
        branch_flag_i = 1'b1;
        branch_addr_i = 32'h10;
        btb_upd_i = 1'b1;
        btb_upd_pc_i = 32'h10;
        btb_upd_tgt_i = 32'h40;
        btb_upd_taken_i = 1'b1;
        cyc();
        branch_flag_i = 1'b0;
        btb_upd_i = 1'b0;
        check("btb_hit_pc", pc_o, 32'h10);
        check("btb_hit_pred", {31'b0, pred_taken_o}, {31'b0, BTB_EN});
        n1 = BTB_EN ? 32'h40 : 32'h14;
        if_ready_i = 1'b1;
        push(32'h10, BTB_EN);
        push(n1, 1'b0);
        cyc();
        check("btb_pred_next", pc_o, n1);
        cyc();
        if_ready_i = 1'b0;
        branch_flag_i = 1'b1;
        branch_addr_i = 32'h10;
        btb_upd_i = 1'b1;
        btb_upd_taken_i = 1'b0;
        cyc();
        branch_flag_i = 1'b0;
        btb_upd_i = 1'b0;
        check("btb_inval_pred", {31'b0, pred_taken_o}, 32'd0);
        if_ready_i = 1'b1;
        push(32'h10, 1'b0);
        cyc();
        if_ready_i = 1'b0;
        check("btb_inval_seq", pc_o, 32'h14);
        branch_flag_i = 1'b1;
        branch_addr_i = 32'h30;
        btb_upd_i = 1'b1;
        btb_upd_taken_i = 1'b1;
        cyc();
        branch_flag_i = 1'b0;
        btb_upd_i = 1'b0;
        check("alias_pc", pc_o, 32'h30);
        check("alias_pred", {31'b0, pred_taken_o}, 32'd0);
        if_ready_i = 1'b1;
        push(32'h30, 1'b0);
        cyc();
        if_ready_i = 1'b0;
        branch_flag_i = 1'b1;
        branch_addr_i = 32'h10;
        cyc();
        branch_flag_i = 1'b0;
        check("reinstall_pred", {31'b0, pred_taken_o}, {31'b0, BTB_EN});
        if_ready_i = 1'b1;
        halt_i = 1'b1;
        push(32'h10, BTB_EN);
        cyc();

        // Reset mid-stream while halted
        halt_i = 1'b0;
        if_ready_i = 1'b0;
        check("halt_pred_pc", pc_o, BTB_EN ? 32'h40 : 32'h14);
        check("halt2_valid", {31'b0, pc_valid_o}, 32'd0);
        #2 rst = 1'b0;
        #1;
        check("midreset_pc", pc_o, 32'h100);
        check("midreset_valid", {31'b0, pc_valid_o}, 32'd0);
        #3 rst = 1'b1;
        cyc();
        check("reboot_pc", pc_o, 32'h100);
        check("reboot_valid", {31'b0, pc_valid_o}, 32'd1);
        branch_flag_i = 1'b1;
        branch_addr_i = 32'h10;
        cyc();
        branch_flag_i = 1'b0;
        check("btb_cleared_pred", {31'b0, pred_taken_o}, 32'd0);
        if_ready_i = 1'b1;
        push(32'h10, 1'b0);
        cyc();
        if_ready_i = 1'b0;
        check("btb_cleared_seq", pc_o, 32'h14);
        cyc();
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
